rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter, ALU and load FIFOs.
// Optional same-edge bypass into an idle write port: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int WAD   = 5,
    parameter int WD    = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [WAD-1:0]      alu_rd,
    input  logic [WD-1:0]       alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [WAD-1:0]      mem_rd,
    input  logic [WD-1:0]       mem_data,
    output logic                RegWrite,
    output logic [WAD-1:0]      AdIn,
    output logic [WD-1:0]       DIn,
    output logic [2**WAD-1:0]   pend,
    output logic                idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic [1:0]     in_valid;
    logic [WAD-1:0] in_rd   [2];
    logic [WD-1:0]  in_data [2];
    logic [WAD-1:0] q_rd    [2][DEPTH];
    logic [WD-1:0]  q_data  [2][DEPTH];
    logic [PW-1:0]  wp      [2];
    logic [PW-1:0]  rp      [2];
    logic [CW-1:0]  cnt     [2];
    logic [1:0]     rdy, hs, ne, push, pop;
    logic           last_grant;
    logic           win, sel, from_q;
    logic [WAD-1:0] win_rd;
    logic [WD-1:0]  win_data;
    logic [PW-1:0]  off;
`ifdef RF_WB_BYPASS_EN
    logic [1:0]     byp;
`endif

    assign in_valid   = {mem_valid, alu_valid};
    assign in_rd[0]   = alu_rd;
    assign in_rd[1]   = mem_rd;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;
    assign alu_ready  = rdy[0];
    assign mem_ready  = rdy[1];
    assign idle       = !ne[0] && !ne[1] && !RegWrite;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            rdy[s] = cnt[s] < CW'(DEPTH);
            hs[s]  = in_valid[s] && rdy[s];
            ne[s]  = cnt[s] != '0;
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign byp = {hs[1] && mem_rd != '0, hs[0] && alu_rd != '0};
`endif

    // Queued heads always beat a bypass; bypass only when both FIFOs are empty.
    always_comb begin
        win    = 1'b0;
        sel    = SRC_ALU;
        from_q = 1'b0;
        unique case (1'b1)
            ne[0] && ne[1]: begin
                win = 1'b1; sel = ~last_grant; from_q = 1'b1;
            end
            ne[0] && !ne[1]: begin
                win = 1'b1; sel = SRC_ALU; from_q = 1'b1;
            end
            !ne[0] && ne[1]: begin
                win = 1'b1; sel = SRC_MEM; from_q = 1'b1;
            end
            default: begin
`ifdef RF_WB_BYPASS_EN
                if (byp[0] && byp[1]) begin
                    win = 1'b1; sel = ~last_grant;
                end else if (byp[0] || byp[1]) begin
                    win = 1'b1; sel = byp[1];
                end
`endif
            end
        endcase
    end

    assign win_rd   = from_q ? q_rd[sel][rp[sel]]   : in_rd[sel];
    assign win_data = from_q ? q_data[sel][rp[sel]] : in_data[sel];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            pop[s]  = win && from_q && (sel == s[0]);
            push[s] = hs[s] && (in_rd[s] != '0)
                      && !(win && !from_q && (sel == s[0]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                wp[s]  <= '0;
                rp[s]  <= '0;
                cnt[s] <= '0;
            end
            last_grant <= SRC_MEM;
            RegWrite   <= 1'b0;
            AdIn       <= '0;
            DIn        <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wp[s] <= wp[s] + PW'(1);
                if (pop[s])  rp[s] <= rp[s] + PW'(1);
                if (push[s] && !pop[s])
                    cnt[s] <= cnt[s] + CW'(1);
                else if (pop[s] && !push[s])
                    cnt[s] <= cnt[s] - CW'(1);
            end
            RegWrite <= win;
            if (win) begin
                AdIn       <= win_rd;
                DIn        <= win_data;
                last_grant <= sel;
            end
        end
    end

    // Storage needs no reset: validity comes from the pointers and counts.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                q_rd[s][wp[s]]   <= in_rd[s];
                q_data[s][wp[s]] <= in_data[s];
            end
        end
    end

    always_comb begin
        pend = '0;
        off  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rp[s];
                if ({1'b0, off} < cnt[s]) pend[q_rd[s][i]] = 1'b1;
            end
        end
        if (RegWrite) pend[AdIn] = 1'b1;
        pend[0] = 1'b0;
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: vector table, hand sequences and a queue-based
// reference model under random traffic.
module tb_rf_wb_arbiter;
    localparam int WAD   = 5;
    localparam int WD    = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, alu_ready;
    logic [WAD-1:0]  alu_rd;
    logic [WD-1:0]   alu_data;
    logic            mem_valid, mem_ready;
    logic [WAD-1:0]  mem_rd;
    logic [WD-1:0]   mem_data;
    logic            RegWrite;
    logic [WAD-1:0]  AdIn;
    logic [WD-1:0]   DIn;
    logic [31:0]     pend;
    logic            idle;

    int n_cmp = 0;
    int n_bad = 0;

    rf_wb_arbiter #(.WAD(WAD), .WD(WD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .RegWrite(RegWrite), .AdIn(AdIn), .DIn(DIn),
        .pend(pend), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic mv,
                        input logic [4:0] mrd, input logic [31:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        @(posedge clk);
        #1;
    endtask

    // Reference model: two queues, an output slot and a last-winner flag.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;
    wr_t         qa[$];
    wr_t         qm[$];
    bit          m_we;
    logic [4:0]  m_ad;
    logic [31:0] m_din;
    bit          m_lg;

    function automatic void model_reset();
        qa.delete();
        qm.delete();
        m_we = 0; m_ad = '0; m_din = '0; m_lg = 1;
    endfunction

    function automatic void model_step(input logic av, input logic [4:0] ard,
                                       input logic [31:0] ad, input logic mv,
                                       input logic [4:0] mrd,
                                       input logic [31:0] md);
        bit ha, hm, ga, gm, ba, bm;
        wr_t w;
        ha = av && (qa.size() < DEPTH);
        hm = mv && (qm.size() < DEPTH);
        ga = 0; gm = 0; ba = 0; bm = 0;
        if (qa.size() > 0 && qm.size() > 0) begin
            if (m_lg) ga = 1; else gm = 1;
        end else if (qa.size() > 0) ga = 1;
        else if (qm.size() > 0) gm = 1;
`ifdef RF_WB_BYPASS_EN
        if (!ga && !gm) begin
            bit ca, cm;
            ca = ha && ard != '0;
            cm = hm && mrd != '0;
            if (ca && cm) begin
                if (m_lg) ba = 1; else bm = 1;
            end else begin
                ba = ca; bm = cm;
            end
        end
`endif
        if (ga) begin
            w = qa.pop_front(); m_we = 1; m_ad = w.rd; m_din = w.d; m_lg = 0;
        end else if (gm) begin
            w = qm.pop_front(); m_we = 1; m_ad = w.rd; m_din = w.d; m_lg = 1;
        end else if (ba) begin
            m_we = 1; m_ad = ard; m_din = ad; m_lg = 0;
        end else if (bm) begin
            m_we = 1; m_ad = mrd; m_din = md; m_lg = 1;
        end else m_we = 0;
        if (ha && ard != '0 && !ba) qa.push_back({ard, ad});
        if (hm && mrd != '0 && !bm) qm.push_back({mrd, md});
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        foreach (qa[i]) p[qa[i].rd] = 1'b1;
        foreach (qm[i]) p[qm[i].rd] = 1'b1;
        if (m_we) p[m_ad] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic cmp_model(input int c);
        check($sformatf("rnd%0d we", c), 64'(RegWrite), 64'(m_we));
        check($sformatf("rnd%0d ad", c), 64'(AdIn), 64'(m_ad));
        check($sformatf("rnd%0d din", c), 64'(DIn), 64'(m_din));
        check($sformatf("rnd%0d pend", c), 64'(pend), 64'(model_pend()));
        check($sformatf("rnd%0d ardy", c), 64'(alu_ready),
              64'(qa.size() < DEPTH));
        check($sformatf("rnd%0d mrdy", c), 64'(mem_ready),
              64'(qm.size() < DEPTH));
        check($sformatf("rnd%0d idle", c), 64'(idle),
              64'(qa.size() == 0 && qm.size() == 0 && !m_we));
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        we;
        logic [4:0]  ead;
        logic [31:0] edin;
        logic [31:0] epend;
        logic        ardy;
        logic        mrdy;
        logic        eidle;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic        av, mv;
        logic [4:0]  ard, mrd;
        logic [31:0] ad, md;

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset we", 64'(RegWrite), 64'(1'b0));
        check("reset ad", 64'(AdIn), 64'(5'd0));
        check("reset din", 64'(DIn), 64'(32'd0));
        check("reset pend", 64'(pend), 64'(32'd0));
        check("reset ardy", 64'(alu_ready), 64'(1'b1));
        check("reset mrdy", 64'(mem_ready), 64'(1'b1));
        check("reset idle", 64'(idle), 64'(1'b1));
        rst_n = 1'b1;

`ifndef RF_WB_BYPASS_EN
        // contention from reset (ALU wins first tie), then a lone write, then rd=0
        tbl[0]  = '{1'b1, 5'd1, 32'hA1, 1'b1, 5'd17, 32'hB1,
                    1'b0, 5'd0, 32'h0, 32'h0002_0002, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 5'd2, 32'hA2, 1'b1, 5'd18, 32'hB2,
                    1'b1, 5'd1, 32'hA1, 32'h0006_0006, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd3, 32'hA3, 1'b1, 5'd19, 32'hB3,
                    1'b1, 5'd17, 32'hB1, 32'h0006_000C, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 5'd4, 32'hA4, 1'b1, 5'd19, 32'hB3,
                    1'b1, 5'd2, 32'hA2, 32'h000C_000C, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd18, 32'hB2, 32'h000C_0008, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd3, 32'hA3, 32'h0008_0008, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd19, 32'hB3, 32'h0008_0000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd19, 32'hB3, 32'h0, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd19, 32'hB3, 32'h20, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd5, 32'hDEADBEEF, 32'h20, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].av, tbl[i].ard, tbl[i].ad,
                 tbl[i].mv, tbl[i].mrd, tbl[i].md);
            check($sformatf("row%0d we", i), 64'(RegWrite), 64'(tbl[i].we));
            check($sformatf("row%0d ad", i), 64'(AdIn), 64'(tbl[i].ead));
            check($sformatf("row%0d din", i), 64'(DIn), 64'(tbl[i].edin));
            check($sformatf("row%0d pend", i), 64'(pend), 64'(tbl[i].epend));
            check($sformatf("row%0d ardy", i), 64'(alu_ready), 64'(tbl[i].ardy));
            check($sformatf("row%0d mrdy", i), 64'(mem_ready), 64'(tbl[i].mrdy));
            check($sformatf("row%0d idle", i), 64'(idle), 64'(tbl[i].eidle));
        end

        // last winner is ALU here, so MEM takes the next tie; then reset mid-flight
        step(1'b1, 5'd6, 32'h66, 1'b1, 5'd22, 32'h2222);
        step(1'b1, 5'd7, 32'h77, 1'b1, 5'd23, 32'h2323);
        check("seq tie mem we", 64'(RegWrite), 64'(1'b1));
        check("seq tie mem ad", 64'(AdIn), 64'(5'd22));
        check("seq pend", 64'(pend), 64'(32'h00C0_00C0));
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst we", 64'(RegWrite), 64'(1'b0));
        check("arst pend", 64'(pend), 64'(32'd0));
        check("arst ardy", 64'(alu_ready), 64'(1'b1));
        check("arst mrdy", 64'(mem_ready), 64'(1'b1));
        check("arst idle", 64'(idle), 64'(1'b1));
        #1;
        rst_n = 1'b1;
        step(1'b1, 5'd8, 32'h88, 1'b1, 5'd24, 32'h2424);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("post-rst tie we", 64'(RegWrite), 64'(1'b1));
        check("post-rst tie ad", 64'(AdIn), 64'(5'd8));
        check("post-rst tie din", 64'(DIn), 64'(32'h88));
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("post-rst 2nd ad", 64'(AdIn), 64'(5'd24));
`else
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        check("bypass we", 64'(RegWrite), 64'(1'b1));
        check("bypass ad", 64'(AdIn), 64'(5'd9));
        check("bypass din", 64'(DIn), 64'(32'h99));
        check("bypass pend", 64'(pend), 64'(32'h200));
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("bypass done", 64'(idle), 64'(1'b1));
`endif

        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            av  = ($urandom_range(0, 9) < 7);
            mv  = ($urandom_range(0, 9) < 6);
            ard = 5'($urandom_range(0, 31));
            mrd = 5'($urandom_range(0, 31));
            ad  = $urandom();
            md  = $urandom();
            step(av, ard, ad, mv, mrd, md);
            model_step(av, ard, ad, mv, mrd, md);
            cmp_model(c);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                cmp_model(c);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
